dispatch: RTL and testbench

- Stage directly downstream of rename. Holds one renamed instruction in a pipeline register.
- Allocates the instruction into the ROB and, in the same cycle, routes it to exactly one issue queue: ALU, BRU or LSU.
- Snoops writeback broadcasts so that a source operand which becomes ready while the instruction waits is marked ready before it enters an issue queue.
- Kills the held instruction on flush or recovery.

---
 rtl/ooop_types.sv | 46 ++++
 rtl/dispatch_wakeup.sv | 24 ++
 rtl/dispatch.sv | 126 ++++++++++++
 tb/tb_dispatch.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ooop_types.sv
// Shared out-of-order pipeline types: renamed packet layout, dispatch targets
// and the writeback wakeup match used by dispatch.
package ooop_types;

  localparam int N_PHYS_REGS = 64;
  localparam int PREG_W      = $clog2(N_PHYS_REGS);
  localparam int ROB_DEPTH   = 32;
  localparam int ROB_W       = $clog2(ROB_DEPTH);
  localparam int N_WB        = 2;

  typedef enum logic [1:0] {
    DISP_ALU,
    DISP_BRU,
    DISP_LSU
  } disp_tgt_e;

  typedef struct packed {
    logic              valid;
    logic [ROB_W-1:0]  rob_tag;
    logic [7:0]        uop;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] prs1;
    logic              prs1_ready;
    logic [PREG_W-1:0] prs2;
    logic              prs2_ready;
    logic              is_load;
    logic              is_store;
    logic              is_branch;
    logic              is_jump;
  } rename_pkt_t;

  // p0 is hardwired zero and never produced by writeback, so it never wakes.
  function automatic logic wake_match(input logic [PREG_W-1:0]      preg,
                                      input logic [N_WB-1:0]        wb_valid,
                                      input logic [N_WB*PREG_W-1:0] wb_preg);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < N_WB; k++) begin
      if (wb_valid[k] && (wb_preg[k*PREG_W +: PREG_W] == preg) && (preg != '0)) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/dispatch_wakeup.sv
// Combinational operand wakeup: sets a source ready bit when any writeback port
// broadcasts its physical register. Ready bits are only ever raised.
module dispatch_wakeup
  import ooop_types::*;
#(
  parameter int N_WB = ooop_types::N_WB
) (
  input  rename_pkt_t              pkt_i,
  input  logic [N_WB-1:0]          wb_valid_i,
  input  logic [N_WB*PREG_W-1:0]   wb_preg_i,
  output rename_pkt_t              pkt_o
);

  always_comb begin
    pkt_o = pkt_i;
    if (wake_match(pkt_i.prs1, wb_valid_i, wb_preg_i)) begin
      pkt_o.prs1_ready = 1'b1;
    end
    if (wake_match(pkt_i.prs2, wb_valid_i, wb_preg_i)) begin
      pkt_o.prs2_ready = 1'b1;
    end
  end

endmodule

// File: rtl/dispatch.sv
// Dispatch stage: holds one renamed instruction, allocates it into the ROB and
// one issue queue in the same cycle, and keeps its source ready bits current.
module dispatch
  import ooop_types::*;
#(
  parameter  int N_PHYS_REGS = ooop_types::N_PHYS_REGS,
  parameter  int ROB_DEPTH   = ooop_types::ROB_DEPTH,
  parameter  int N_WB        = ooop_types::N_WB,
  localparam int REG_W       = $clog2(N_PHYS_REGS),
  localparam int TAG_W       = $clog2(ROB_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   recover_i,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  rename_pkt_t            pkt_in,
  output logic                   rob_valid_o,
  input  logic                   rob_ready_i,
  output logic                   alu_valid_o,
  input  logic                   alu_ready_i,
  output logic                   bru_valid_o,
  input  logic                   bru_ready_i,
  output logic                   lsu_valid_o,
  input  logic                   lsu_ready_i,
  output rename_pkt_t            pkt_o,
  input  logic [N_WB-1:0]        wb_valid_i,
  input  logic [N_WB*REG_W-1:0]  wb_preg_i,
  output logic [31:0]            stall_cnt_o
);

  logic        hold_v_q, hold_v_d;
  rename_pkt_t hold_q, hold_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  rename_pkt_t in_wk, held_wk;
  disp_tgt_e   tgt;
  logic        tgt_ready;
  logic        kill, out_fire, in_fire;

  dispatch_wakeup #(.N_WB(N_WB)) u_wake_in (
    .pkt_i      (pkt_in),
    .wb_valid_i (wb_valid_i),
    .wb_preg_i  (wb_preg_i),
    .pkt_o      (in_wk)
  );

  dispatch_wakeup #(.N_WB(N_WB)) u_wake_hold (
    .pkt_i      (hold_q),
    .wb_valid_i (wb_valid_i),
    .wb_preg_i  (wb_preg_i),
    .pkt_o      (held_wk)
  );

  always_comb begin
    tgt = DISP_ALU;
    if (hold_q.is_load || hold_q.is_store) begin
      tgt = DISP_LSU;
    end else if (hold_q.is_branch || hold_q.is_jump) begin
      tgt = DISP_BRU;
    end
  end

  always_comb begin
    case (tgt)
      DISP_LSU: tgt_ready = lsu_ready_i;
      DISP_BRU: tgt_ready = bru_ready_i;
      default:  tgt_ready = alu_ready_i;
    endcase
  end

  // Flush and recover both kill the held op: it is younger than any resolver.
  assign kill     = flush_i | recover_i;
  assign out_fire = hold_v_q & rob_ready_i & tgt_ready & ~kill;
  assign ready_out = ~rst & ~kill & (~hold_v_q | out_fire);
  assign in_fire  = valid_in & ready_out;

  assign rob_valid_o = out_fire;
  assign alu_valid_o = out_fire & (tgt == DISP_ALU);
  assign bru_valid_o = out_fire & (tgt == DISP_BRU);
  assign lsu_valid_o = out_fire & (tgt == DISP_LSU);
  assign stall_cnt_o = stall_cnt_q;

  always_comb begin
    pkt_o = '0;
    if (hold_v_q) begin
      pkt_o         = held_wk;
      pkt_o.rob_tag = TAG_W'(held_wk.rob_tag);
      pkt_o.valid   = 1'b1;
    end
  end

  always_comb begin
    hold_v_d    = hold_v_q;
    hold_d      = hold_q;
    stall_cnt_d = stall_cnt_q;
    if (kill) begin
      hold_v_d = 1'b0;
    end else if (in_fire) begin
      hold_v_d     = 1'b1;
      hold_d       = in_wk;
      hold_d.valid = 1'b1;
    end else if (out_fire) begin
      hold_v_d = 1'b0;
    end else if (hold_v_q) begin
      hold_d = held_wk;
    end
    if (hold_v_q && !out_fire && !kill) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v_q    <= 1'b0;
      hold_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_q      <= hold_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_dispatch.sv
// Randomised and directed bench for dispatch against a one-slot reference model.
module tb_dispatch;
  import ooop_types::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush_i, recover_i, valid_in;
  logic                    ready_out;
  rename_pkt_t             pkt_in, pkt_o;
  logic                    rob_valid_o, rob_ready_i;
  logic                    alu_valid_o, alu_ready_i;
  logic                    bru_valid_o, bru_ready_i;
  logic                    lsu_valid_o, lsu_ready_i;
  logic [N_WB-1:0]         wb_valid_i;
  logic [N_WB*PREG_W-1:0]  wb_preg_i;
  logic [31:0]             stall_cnt_o;

  int checks = 0;
  int failures = 0;

  // reference model: one optional held packet plus the stall count
  logic        m_v;
  rename_pkt_t m_pkt;
  logic [31:0] m_stall;

  dispatch dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .recover_i   (recover_i),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .pkt_in      (pkt_in),
    .rob_valid_o (rob_valid_o),
    .rob_ready_i (rob_ready_i),
    .alu_valid_o (alu_valid_o),
    .alu_ready_i (alu_ready_i),
    .bru_valid_o (bru_valid_o),
    .bru_ready_i (bru_ready_i),
    .lsu_valid_o (lsu_valid_o),
    .lsu_ready_i (lsu_ready_i),
    .pkt_o       (pkt_o),
    .wb_valid_i  (wb_valid_i),
    .wb_preg_i   (wb_preg_i),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic rename_pkt_t m_wake(input rename_pkt_t p, input logic [N_WB-1:0] v,
                                         input logic [N_WB*PREG_W-1:0] pr);
    rename_pkt_t r;
    logic [PREG_W-1:0] reg_k;
    r = p;
    for (int k = 0; k < N_WB; k++) begin
      reg_k = pr[k*PREG_W +: PREG_W];
      if (v[k] && reg_k != 0) begin
        if (reg_k == p.prs1) r.prs1_ready = 1'b1;
        if (reg_k == p.prs2) r.prs2_ready = 1'b1;
      end
    end
    return r;
  endfunction

  // kind: 0 ALU, 1 branch, 2 load, 3 store, 4 jump
  function automatic rename_pkt_t mk_pkt(input int kind, input int p1, input logic r1,
                                         input int p2, input logic r2, input int tag);
    rename_pkt_t p;
    p = '0;
    p.valid      = 1'b1;
    p.rob_tag    = ROB_W'(tag);
    p.uop        = 8'(tag * 3 + 1);
    p.prd        = PREG_W'(tag + 9);
    p.prs1       = PREG_W'(p1);
    p.prs1_ready = r1;
    p.prs2       = PREG_W'(p2);
    p.prs2_ready = r2;
    p.is_branch  = (kind == 1);
    p.is_load    = (kind == 2);
    p.is_store   = (kind == 3);
    p.is_jump    = (kind == 4);
    return p;
  endfunction

  // Called at a negedge with inputs already driven; checks, clocks the model, returns at the next negedge.
  task automatic step();
    logic        mem, br, fire, sel_rdy, exp_ro, kl;
    rename_pkt_t exp_pkt;
    #1;
    mem     = m_pkt.is_load | m_pkt.is_store;
    br      = !mem && (m_pkt.is_branch | m_pkt.is_jump);
    sel_rdy = mem ? lsu_ready_i : (br ? bru_ready_i : alu_ready_i);
    kl      = flush_i | recover_i;
    fire    = m_v && rob_ready_i && sel_rdy && !kl;
    exp_ro  = !kl && (!m_v || fire);
    exp_pkt = '0;
    if (m_v) begin
      exp_pkt = m_wake(m_pkt, wb_valid_i, wb_preg_i);
      exp_pkt.valid = 1'b1;
    end
    check("ready_out", 64'(ready_out), 64'(exp_ro));
    check("rob_valid", 64'(rob_valid_o), 64'(fire));
    check("alu_valid", 64'(alu_valid_o), 64'(fire && !mem && !br));
    check("bru_valid", 64'(bru_valid_o), 64'(fire && br));
    check("lsu_valid", 64'(lsu_valid_o), 64'(fire && mem));
    check("pkt_o", 64'(pkt_o), 64'(exp_pkt));
    check("stall_cnt", 64'(stall_cnt_o), 64'(m_stall));
    @(posedge clk);
    if (m_v && !fire && !kl) m_stall = m_stall + 1;
    if (kl) begin
      m_v = 1'b0;
    end else if (valid_in && exp_ro) begin
      m_v = 1'b1;
      m_pkt = m_wake(pkt_in, wb_valid_i, wb_preg_i);
      m_pkt.valid = 1'b1;
    end else if (fire) begin
      m_v = 1'b0;
    end else if (m_v) begin
      m_pkt = m_wake(m_pkt, wb_valid_i, wb_preg_i);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush_i = 0; recover_i = 0; valid_in = 0; pkt_in = '0;
    rob_ready_i = 1; alu_ready_i = 1; bru_ready_i = 1; lsu_ready_i = 1;
    wb_valid_i = '0; wb_preg_i = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_v = 1'b0; m_pkt = '0; m_stall = '0;
    repeat (2) @(negedge clk);
    check("rst_ready_out", 64'(ready_out), 64'd0);
    check("rst_rob_valid", 64'(rob_valid_o), 64'd0);
    check("rst_pkt_o", 64'(pkt_o), 64'd0);
    check("rst_stall", 64'(stall_cnt_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // back-to-back ALU stream
    for (int i = 0; i < 4; i++) begin
      valid_in = 1; pkt_in = mk_pkt(0, i + 1, 1, i + 2, 1, i);
      step();
    end
    valid_in = 0;
    step();
    check("stream_stall", 64'(stall_cnt_o), 64'd0);

    // load held while LSU queue is full
    valid_in = 1; pkt_in = mk_pkt(2, 3, 1, 4, 1, 7); lsu_ready_i = 0;
    step();
    valid_in = 0;
    repeat (3) step();
    check("load_stall3", 64'(stall_cnt_o), 64'd3);
    check("load_blocked_rob", 64'(rob_valid_o), 64'd0);
    lsu_ready_i = 1;
    #1;
    check("load_go_lsu", 64'(lsu_valid_o), 64'd1);
    step();

    // same-cycle wakeup on port 1 of a held ALU op
    valid_in = 1; pkt_in = mk_pkt(0, 17, 0, 5, 1, 9); alu_ready_i = 0;
    step();
    valid_in = 0; wb_valid_i = 2'b10; wb_preg_i = {6'd17, 6'd0};
    #1;
    check("wake_same_cycle", 64'(pkt_o.prs1_ready), 64'd1);
    step();
    wb_valid_i = '0; wb_preg_i = '0;
    #1;
    check("wake_sticky", 64'(pkt_o.prs1_ready), 64'd1);
    step();
    alu_ready_i = 1;
    step();

    // recover kills a dispatch-ready branch
    valid_in = 1; pkt_in = mk_pkt(1, 2, 1, 3, 1, 11); bru_ready_i = 0;
    step();
    bru_ready_i = 1; recover_i = 1; pkt_in = mk_pkt(0, 1, 1, 1, 1, 12);
    #1;
    check("recover_bru", 64'(bru_valid_o), 64'd0);
    check("recover_ready", 64'(ready_out), 64'd0);
    step();
    recover_i = 0; valid_in = 0;
    #1;
    check("recover_empty", 64'(pkt_o.valid), 64'd0);
    step();

    // p0 broadcast must not wake a p0 source
    valid_in = 1; pkt_in = mk_pkt(0, 6, 1, 0, 0, 13); alu_ready_i = 0;
    wb_valid_i = 2'b11; wb_preg_i = '0;
    step();
    valid_in = 0;
    #1;
    check("x0_no_wake", 64'(pkt_o.prs2_ready), 64'd0);
    step();
    wb_valid_i = '0;
    alu_ready_i = 1;
    step();

    // asynchronous reset in the middle of a hold
    valid_in = 1; pkt_in = mk_pkt(3, 4, 1, 5, 1, 14); lsu_ready_i = 0;
    step();
    valid_in = 0;
    step();
    lsu_ready_i = 1;
    #2 rst = 1'b1;
    #1;
    check("arst_ready_out", 64'(ready_out), 64'd0);
    check("arst_rob_valid", 64'(rob_valid_o), 64'd0);
    check("arst_lsu_valid", 64'(lsu_valid_o), 64'd0);
    check("arst_pkt_o", 64'(pkt_o), 64'd0);
    m_v = 1'b0; m_pkt = '0; m_stall = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("arst_stall", 64'(stall_cnt_o), 64'd0);
    step();

    // randomised traffic
    for (int c = 0; c < 500; c++) begin
      valid_in    = ($urandom_range(0, 9) < 7);
      pkt_in      = mk_pkt($urandom_range(0, 4), $urandom_range(0, 7), $urandom_range(0, 1),
                           $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31));
      rob_ready_i = ($urandom_range(0, 9) < 8);
      alu_ready_i = ($urandom_range(0, 9) < 7);
      bru_ready_i = ($urandom_range(0, 9) < 7);
      lsu_ready_i = ($urandom_range(0, 9) < 6);
      flush_i     = ($urandom_range(0, 99) < 4);
      recover_i   = ($urandom_range(0, 99) < 4);
      wb_valid_i  = N_WB'($urandom_range(0, 3));
      wb_preg_i   = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
